bitpack_store: RTL and testbench

Parametrised variable-length bit packer with on-chip byte storage for compressed sample streams. Accepts codes of 0..CODE_MAX_BITS bits per handshake, packs them LSB-first into a byte stream, and writes one byte per cycle into a simple dual-port byte RAM. It also provides an explicit flush that zero-pads the final partial byte, and a registered read port for UART readout. It sits between the compressor output and the readout path.

---
 rtl/bitpack_store_pkg.sv | 16 +
 rtl/bitpack_store_ram.sv | 30 +++
 rtl/bitpack_store.sv | 203 ++++++++++++++++++++
 tb/tb_bitpack_store.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitpack_store_pkg.sv
// Shared parameters and types for the bitpack_store block.
package bitpack_store_pkg;

  localparam int CODE_MAX_BITS_DEF = 20;
  localparam int BUF_BITS_DEF      = 40;
  localparam int MEM_BYTES_DEF     = 2048;

  // Flush sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    PAD   = 2'd2,
    DONE  = 2'd3
  } bitpack_state_t;

endpackage

// File: rtl/bitpack_store_ram.sv
// Byte-wide simple dual-port RAM: synchronous write and a registered
// read-first read. A read and a write to the same address on the same
// edge return the previous contents.
module bitpack_store_ram #(
  parameter int MEM_BYTES = 2048,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MEM_BYTES];

  // Write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, cleared by reset so readout starts at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= 8'h00;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/bitpack_store.sv
// Variable-length LSB-first bit packer feeding an on-chip byte store.
// Build option: define BITPACK_STORE_WRAP_EN for circular storage
// (pointer wraps, oldest data overwritten); otherwise storage is linear
// and stops when full.
//
// Input handshake: a code transfers on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on internal state (never
// on in_valid or in_len), so the producer may hold in_valid high and
// change in_code/in_len freely until the transfer edge.
module bitpack_store
  import bitpack_store_pkg::*;
#(
  parameter int CODE_MAX_BITS = CODE_MAX_BITS_DEF,
  parameter int BUF_BITS      = BUF_BITS_DEF,
  parameter int MEM_BYTES     = MEM_BYTES_DEF,
  localparam int LENW = $clog2(CODE_MAX_BITS + 1),
  localparam int AW   = $clog2(MEM_BYTES),
  localparam int CW   = $clog2(BUF_BITS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CODE_MAX_BITS-1:0] in_code,
  input  logic [LENW-1:0]          in_len,
  input  logic                     flush_req,
  output logic                     flush_busy,
  output logic                     flush_done,
  input  logic [AW-1:0]            rd_addr,
  output logic [7:0]               rd_data,
  output logic [AW-1:0]            wr_ptr,
  output logic [AW:0]              bytes_stored,
  output logic                     mem_full,
  output logic                     wrapped,
  output bitpack_state_t           dbg_state,
  output logic [CW-1:0]            dbg_bit_count
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(MEM_BYTES);
  localparam logic [AW-1:0] LAST_PTR = AW'(MEM_BYTES - 1);
  localparam logic [CW-1:0] READY_MAX = CW'(BUF_BITS - CODE_MAX_BITS);

  bitpack_state_t           state, state_next;
  logic [BUF_BITS-1:0]      pack_buf, buf_next;
  logic [CW-1:0]            bit_count, cnt_next;
  logic [LENW-1:0]          len_eff;
  logic [CODE_MAX_BITS-1:0] code_masked;
  logic [7:0]               pad_mask;
  logic [7:0]               wr_byte;
  logic                     wr_en;
  logic                     writable;
  logic                     have_byte;
  logic                     accept;
  logic                     mem_full_q;

  assign have_byte = (bit_count >= CW'(8));
  assign in_ready  = !reset && (bit_count <= READY_MAX) && (state == IDLE)
                     && !(mem_full_q && have_byte);
  assign accept    = in_valid && in_ready;

  assign dbg_state     = state;
  assign dbg_bit_count = bit_count;
  assign mem_full      = mem_full_q;

  // Clamp the length and zero every code bit at or above it.
  always_comb begin
    len_eff = (in_len > LENW'(CODE_MAX_BITS)) ? LENW'(CODE_MAX_BITS) : in_len;
    code_masked = '0;
    for (int i = 0; i < CODE_MAX_BITS; i++) begin
      code_masked[i] = in_code[i] & (i < int'(len_eff));
    end
    pad_mask = '0;
    for (int i = 0; i < 8; i++) begin
      pad_mask[i] = (i < int'(bit_count));
    end
  end

  // Drain, accept and flush sequencing. In IDLE the drain shift happens
  // first so an accepted code lands just above the bits that remain.
  // On flush the next state is chosen from the post-accept bit count so
  // the flush takes ceil(bits/8) write cycles plus the DONE cycle.
  always_comb begin
    state_next = state;
    buf_next   = pack_buf;
    cnt_next   = bit_count;
    wr_en      = 1'b0;
    wr_byte    = pack_buf[7:0];
    case (state)
      IDLE: begin
        if (have_byte && writable) begin
          wr_en    = 1'b1;
          buf_next = pack_buf >> 8;
          cnt_next = bit_count - CW'(8);
        end
        if (accept) begin
          buf_next = buf_next | (BUF_BITS'(code_masked) << cnt_next);
          cnt_next = cnt_next + CW'(len_eff);
        end
        if (flush_req) begin
          if (cnt_next >= CW'(8))      state_next = DRAIN;
          else if (cnt_next != '0)     state_next = PAD;
          else                         state_next = DONE;
        end
      end
      DRAIN: begin
        if (!writable) begin
          buf_next   = '0;
          cnt_next   = '0;
          state_next = DONE;
        end else if (have_byte) begin
          wr_en    = 1'b1;
          buf_next = pack_buf >> 8;
          cnt_next = bit_count - CW'(8);
          if (cnt_next >= CW'(8))      state_next = DRAIN;
          else if (cnt_next != '0)     state_next = PAD;
          else                         state_next = DONE;
        end else begin
          state_next = (bit_count != '0) ? PAD : DONE;
        end
      end
      PAD: begin
        wr_en      = writable;
        wr_byte    = pack_buf[7:0] & pad_mask;
        buf_next   = '0;
        cnt_next   = '0;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Packing buffer, FSM state and registered flush status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pack_buf   <= '0;
      bit_count  <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      pack_buf   <= buf_next;
      bit_count  <= cnt_next;
      flush_busy <= (state_next != IDLE);
      flush_done <= (state_next == DONE);
    end
  end

`ifdef BITPACK_STORE_WRAP_EN
  logic wrapped_q;

  assign writable   = 1'b1;
  assign mem_full_q = 1'b0;
  assign wrapped    = wrapped_q;

  // Circular pointer; a write to address 0 once the store has been
  // completely filled means the oldest byte is being overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      bytes_stored <= '0;
      wrapped_q    <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (bytes_stored != FULL_CNT) bytes_stored <= bytes_stored + (AW + 1)'(1);
      if (wr_ptr == '0 && bytes_stored == FULL_CNT) wrapped_q <= 1'b1;
    end
  end
`else
  logic [AW:0] bytes_inc;

  assign writable  = !mem_full_q;
  assign wrapped   = 1'b0;
  assign bytes_inc = bytes_stored + (AW + 1)'(1);

  // Linear pointer that parks on the last address; full stops all writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      bytes_stored <= '0;
      mem_full_q   <= 1'b0;
    end else if (wr_en) begin
      if (wr_ptr != LAST_PTR) wr_ptr <= wr_ptr + AW'(1);
      bytes_stored <= bytes_inc;
      mem_full_q   <= (bytes_inc == FULL_CNT);
    end
  end
`endif

  bitpack_store_ram #(.MEM_BYTES(MEM_BYTES)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_byte),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_bitpack_store.sv
// Directed bench for bitpack_store: a default-size instance for packing,
// flush and streaming, and a 16-byte instance for the storage limit.
module tb_bitpack_store;
  import bitpack_store_pkg::*;

  localparam int AW  = 11;
  localparam int AWS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic        in_valid = 0, in_ready, flush_req = 0, flush_busy, flush_done;
  logic [19:0] in_code = 0;
  logic [4:0]  in_len = 0;
  logic [AW-1:0] rd_addr = 0, wr_ptr;
  logic [7:0]  rd_data;
  logic [AW:0] bytes_stored;
  logic        mem_full, wrapped;
  bitpack_state_t dbg_state;
  logic [5:0]  dbg_bit_count;

  // small instance
  logic        s_in_valid = 0, s_in_ready, s_flush_req = 0, s_flush_busy, s_flush_done;
  logic [19:0] s_in_code = 0;
  logic [4:0]  s_in_len = 0;
  logic [AWS-1:0] s_rd_addr = 0, s_wr_ptr;
  logic [7:0]  s_rd_data;
  logic [AWS:0] s_bytes_stored;
  logic        s_mem_full, s_wrapped;
  bitpack_state_t s_dbg_state;
  logic [5:0]  s_dbg_bit_count;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  bitpack_store dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_len(in_len), .flush_req(flush_req),
    .flush_busy(flush_busy), .flush_done(flush_done), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_ptr(wr_ptr), .bytes_stored(bytes_stored),
    .mem_full(mem_full), .wrapped(wrapped), .dbg_state(dbg_state),
    .dbg_bit_count(dbg_bit_count)
  );

  bitpack_store #(.MEM_BYTES(16)) dut_small (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_code(s_in_code), .in_len(s_in_len), .flush_req(s_flush_req),
    .flush_busy(s_flush_busy), .flush_done(s_flush_done), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .wr_ptr(s_wr_ptr), .bytes_stored(s_bytes_stored),
    .mem_full(s_mem_full), .wrapped(s_wrapped), .dbg_state(s_dbg_state),
    .dbg_bit_count(s_dbg_bit_count)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1; in_valid = 0; flush_req = 0; s_in_valid = 0; s_flush_req = 0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic push(input logic [19:0] code, input logic [4:0] len);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1; in_code = code; in_len = len;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) begin bad++; $display("FAIL push_ready_timeout got=0 exp=1"); end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic read_byte(input logic [AW-1:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1 d = rd_data;
  endtask

  task automatic read_small(input logic [AWS-1:0] a, output logic [7:0] d);
    @(negedge clk);
    s_rd_addr = a;
    @(posedge clk);
    #1 d = s_rd_data;
  endtask

  task automatic run_flush(output int pulses, output int busy_seen);
    @(negedge clk);
    flush_req = 1;
    @(posedge clk);
    #1 flush_req = 0;
    pulses = 0; busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (flush_done) pulses++;
      if (flush_busy) busy_seen++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_reset got=%b exp=0", in_ready); end
    @(negedge clk);
    reset = 0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    total++; if ({flush_busy, flush_done, mem_full, wrapped} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {flush_busy, flush_done, mem_full, wrapped}); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    total++; if (wr_ptr !== '0 || bytes_stored !== '0) begin bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", wr_ptr, bytes_stored); end
    total++; if (dbg_bit_count !== 6'd0 || dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg_bit_count, dbg_state); end
  endtask

  task automatic test_single_byte();
    logic [7:0] d;
    do_reset();
    push(20'hA5, 5'd8);
    @(negedge clk);
    total++; if (dbg_bit_count !== 6'd8 || bytes_stored !== 12'd0) begin bad++; $display("FAIL single_pre_write got=%0d/%0d exp=8/0", dbg_bit_count, bytes_stored); end
    @(negedge clk);
    total++; if (bytes_stored !== 12'd1 || wr_ptr !== 11'd1) begin bad++; $display("FAIL single_post_write got=%0d/%0d exp=1/1", bytes_stored, wr_ptr); end
    total++; if (dbg_bit_count !== 6'd0) begin bad++; $display("FAIL single_bit_count got=%0d exp=0", dbg_bit_count); end
    read_byte(11'd0, d);
    total++; if (d !== 8'hA5) begin bad++; $display("FAIL single_mem0 got=%h exp=a5", d); end
  endtask

  task automatic test_pack_two();
    logic [7:0] d;
    do_reset();
    push(20'h1, 5'd2);
    push(20'h2A, 5'd6);
    repeat (2) @(negedge clk);
    total++; if (dbg_bit_count !== 6'd0 || bytes_stored !== 12'd1) begin bad++; $display("FAIL pack_two_counts got=%0d/%0d exp=0/1", dbg_bit_count, bytes_stored); end
    read_byte(11'd0, d);
    total++; if (d !== 8'hA9) begin bad++; $display("FAIL pack_two_mem0 got=%h exp=a9", d); end
  endtask

  task automatic test_mask_clamp();
    logic [7:0] d;
    logic [7:0] exp_b [4];
    int p, b;
    exp_b[0] = 8'h07; exp_b[1] = 8'hDE; exp_b[2] = 8'hBC; exp_b[3] = 8'h0A;
    do_reset();
    push(20'hFFFFF, 5'd3);
    push(20'h000FF, 5'd0);
    @(negedge clk);
    total++; if (dbg_bit_count !== 6'd3) begin bad++; $display("FAIL mask_len0_count got=%0d exp=3", dbg_bit_count); end
    push(20'h0, 5'd5);
    push(20'hABCDE, 5'd31);
    @(negedge clk);
    total++; if (dbg_bit_count !== 6'd20) begin bad++; $display("FAIL clamp_count got=%0d exp=20", dbg_bit_count); end
    run_flush(p, b);
    total++; if (bytes_stored !== 12'd4) begin bad++; $display("FAIL clamp_bytes got=%0d exp=4", bytes_stored); end
    for (int i = 0; i < 4; i++) begin
      read_byte(AW'(i), d);
      total++; if (d !== exp_b[i]) begin bad++; $display("FAIL mask_clamp_mem%0d got=%h exp=%h", i, d, exp_b[i]); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] d;
    logic [7:0] exp_b [3];
    int p, b;
    exp_b[0] = 8'hDE; exp_b[1] = 8'hBC; exp_b[2] = 8'h0A;
    do_reset();
    push(20'hABCDE, 5'd20);
    run_flush(p, b);
    total++; if (p != 1) begin bad++; $display("FAIL flush_done_pulses got=%0d exp=1", p); end
    total++; if (b < 1 || b > 4) begin bad++; $display("FAIL flush_busy_cycles got=%0d exp=1..4", b); end
    total++; if (bytes_stored !== 12'd3 || dbg_state !== IDLE) begin bad++; $display("FAIL flush_bytes got=%0d exp=3", bytes_stored); end
    for (int i = 0; i < 3; i++) begin
      read_byte(AW'(i), d);
      total++; if (d !== exp_b[i]) begin bad++; $display("FAIL flush_mem%0d got=%h exp=%h", i, d, exp_b[i]); end
    end
  endtask

  task automatic test_flush_edges();
    logic [7:0] d;
    int p, b;
    do_reset();
    @(negedge clk);
    in_valid = 1; in_code = 20'hFFF3C; in_len = 5'd6; flush_req = 1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL same_cycle_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1 in_valid = 0; flush_req = 0;
    p = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (flush_done) p++;
    end
    total++; if (p != 1) begin bad++; $display("FAIL same_cycle_pulses got=%0d exp=1", p); end
    total++; if (bytes_stored !== 12'd1) begin bad++; $display("FAIL same_cycle_bytes got=%0d exp=1", bytes_stored); end
    read_byte(11'd0, d);
    total++; if (d !== 8'h3C) begin bad++; $display("FAIL same_cycle_mem0 got=%h exp=3c", d); end
    run_flush(p, b);
    total++; if (p != 1 || bytes_stored !== 12'd1) begin bad++; $display("FAIL empty_flush got=%0d/%0d exp=1/1", p, bytes_stored); end
  endtask

  task automatic test_stream();
    logic [63:0] acc;
    logic [19:0] code;
    logic [7:0]  d;
    int nb, hi, lo, p, b, n;
    logic hs;
    acc = '0; nb = 0; hi = 0; lo = 0;
    exp_q.delete();
    do_reset();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      code = 20'($urandom_range(0, 32'hFFFFF));
      in_valid = 1; in_code = code; in_len = 5'd20;
      hs = in_ready;
      if (hs) hi++; else lo++;
      @(posedge clk);
      if (hs) begin
        acc = acc | ({44'd0, code} << nb);
        nb += 20;
        while (nb >= 8) begin
          exp_q.push_back(acc[7:0]);
          acc = acc >> 8;
          nb -= 8;
        end
      end
    end
    #1 in_valid = 0;
    if (nb > 0) exp_q.push_back(acc[7:0]);
    run_flush(p, b);
    total++; if (hi == 0 || lo == 0) begin bad++; $display("FAIL stream_ready_toggle got=hi%0d/lo%0d exp=both>0", hi, lo); end
    total++; if (p != 1 || dbg_bit_count !== 6'd0) begin bad++; $display("FAIL stream_flush got=%0d/%0d exp=1/0", p, dbg_bit_count); end
    total++; if (int'(bytes_stored) != exp_q.size()) begin bad++; $display("FAIL stream_count got=%0d exp=%0d", bytes_stored, exp_q.size()); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      read_byte(AW'(i), d);
      total++; if (d !== exp_q[i]) begin bad++; $display("FAIL stream_byte%0d got=%h exp=%h", i, d, exp_q[i]); end
    end
  endtask

  task automatic test_full_small();
    logic [7:0] d;
    int n, p;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s_in_valid = 1; s_in_code = 20'(8'h30 + i); s_in_len = 5'd8;
      n = 0;
      while (!s_in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      total++; if (!s_in_ready) begin bad++; $display("FAIL full_push%0d_ready got=0 exp=1", i); end
      @(posedge clk);
      #1 s_in_valid = 0;
    end
    repeat (3) @(negedge clk);
    total++; if (s_bytes_stored !== 5'd16) begin bad++; $display("FAIL full_bytes got=%0d exp=16", s_bytes_stored); end
`ifdef BITPACK_STORE_WRAP_EN
    total++; if (s_mem_full !== 1'b0 || s_wrapped !== 1'b1) begin bad++; $display("FAIL wrap_flags got=%b%b exp=01", s_mem_full, s_wrapped); end
    total++; if (s_wr_ptr !== 4'd1) begin bad++; $display("FAIL wrap_ptr got=%0d exp=1", s_wr_ptr); end
    read_small(4'd0, d);
    total++; if (d !== 8'h40) begin bad++; $display("FAIL wrap_mem0 got=%h exp=40", d); end
    read_small(4'd1, d);
    total++; if (d !== 8'h31) begin bad++; $display("FAIL wrap_mem1 got=%h exp=31", d); end
`else
    total++; if (s_mem_full !== 1'b1 || s_wrapped !== 1'b0) begin bad++; $display("FAIL full_flags got=%b%b exp=10", s_mem_full, s_wrapped); end
    total++; if (s_in_ready !== 1'b0 || s_wr_ptr !== 4'd15) begin bad++; $display("FAIL full_ready_ptr got=%b/%0d exp=0/15", s_in_ready, s_wr_ptr); end
    read_small(4'd0, d);
    total++; if (d !== 8'h30) begin bad++; $display("FAIL full_mem0 got=%h exp=30", d); end
    read_small(4'd15, d);
    total++; if (d !== 8'h3F) begin bad++; $display("FAIL full_mem15 got=%h exp=3f", d); end
    @(negedge clk);
    s_flush_req = 1;
    @(posedge clk);
    #1 s_flush_req = 0;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_flush_done) p++;
    end
    total++; if (p != 1 || s_dbg_bit_count !== 6'd0 || s_bytes_stored !== 5'd16) begin bad++; $display("FAIL full_flush got=%0d/%0d/%0d exp=1/0/16", p, s_dbg_bit_count, s_bytes_stored); end
`endif
  endtask

  task automatic test_reset_mid_flush();
    int p;
    do_reset();
    push(20'hABCDE, 5'd20);
    @(negedge clk);
    flush_req = 1;
    @(posedge clk);
    #1 flush_req = 0;
    @(negedge clk);
    total++; if (dbg_state !== DRAIN || dbg_bit_count !== 6'd12) begin bad++; $display("FAIL mid_flush_setup got=%0d/%0d exp=1/12", dbg_state, dbg_bit_count); end
    reset = 1;
    #1;
    total++; if (flush_busy !== 1'b0 || dbg_bit_count !== 6'd0) begin bad++; $display("FAIL mid_flush_reset got=%b/%0d exp=0/0", flush_busy, dbg_bit_count); end
    @(negedge clk);
    reset = 0;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (flush_done) p++;
    end
    total++; if (p != 0 || bytes_stored !== 12'd0) begin bad++; $display("FAIL mid_flush_no_done got=%0d/%0d exp=0/0", p, bytes_stored); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_single_byte();
    test_pack_two();
    test_mask_clamp();
    test_flush();
    test_flush_edges();
    test_stream();
    test_full_small();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
